// File: rtl/aes_pkg.sv
// Shared definitions for the AES-128 inverse-cipher controller.
//   AES_NR / AES_BW : round count and block width defaults
//   block_t, rnd_t  : data block and round-counter types
//   ctrl_state_t    : sequencer states
//   key_idx_valid() : range check for round-key table indices
package aes_pkg;

  localparam int AES_NR = 10;
  localparam int AES_BW = 128;

  typedef logic [AES_BW-1:0] block_t;
  typedef logic [3:0]        rnd_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ROUND = 3'd2,
    FINAL = 3'd3,
    HOLD  = 3'd4
  } ctrl_state_t;

  // Table holds entries 0..nr; anything above is out of range.
  function automatic logic key_idx_valid(input rnd_t idx, input int nr);
    return (int'(idx) <= nr);
  endfunction

endpackage

// File: rtl/invcipher_ctrl_if.sv
// Bundle of every non-clock/reset signal of the inverse-cipher controller.
//   key_*            : round-key table load port from the key-expansion block
//   in_*             : ciphertext valid/ready port
//   out_*            : plaintext valid/ready port
//   core_*           : connection to the invcipher datapath
// modport slave  : the controller's view
// modport master : the surrounding system's view
interface invcipher_ctrl_if
  import aes_pkg::*;
#(
  parameter int BW = AES_BW
);

  logic          key_we;
  rnd_t          key_idx;
  logic [BW-1:0] key_data;
  logic          key_commit;
  logic          keys_valid;

  logic          in_valid;
  logic          in_ready;
  logic [BW-1:0] in_data;

  logic          out_valid;
  logic          out_ready;
  logic [BW-1:0] out_data;

  logic          core_reset;
  logic          core_done;
  logic [BW-1:0] core_key;
  logic [BW-1:0] core_in;
  logic [BW-1:0] core_out;

  modport master (
    output key_we, key_idx, key_data, key_commit,
    output in_valid, in_data, out_ready, core_out,
    input  keys_valid, in_ready, out_valid, out_data,
    input  core_reset, core_done, core_key, core_in
  );

  modport slave (
    input  key_we, key_idx, key_data, key_commit,
    input  in_valid, in_data, out_ready, core_out,
    output keys_valid, in_ready, out_valid, out_data,
    output core_reset, core_done, core_key, core_in
  );

endinterface

// File: rtl/inv_round_key_table.sv
// Round-key storage for the inverse cipher: NR+1 entries of BW bits.
//   clk     : clock
//   i_we    : write strobe (already qualified by the caller)
//   i_widx  : entry written on i_we
//   i_wdata : key written
//   i_ridx  : entry read (the sequencer's round counter)
//   o_rdata : combinational read data, zero for out-of-range indices
// Contents are deliberately not reset: a committed table survives a
// controller reset and only needs a fresh commit.
module inv_round_key_table
  import aes_pkg::*;
#(
  parameter int NR = AES_NR,
  parameter int BW = AES_BW
) (
  input  logic          clk,
  input  logic          i_we,
  input  rnd_t          i_widx,
  input  logic [BW-1:0] i_wdata,
  input  rnd_t          i_ridx,
  output logic [BW-1:0] o_rdata
);

  logic [BW-1:0] w_entry [NR+1];

  generate
    for (genvar gi = 0; gi <= NR; gi++) begin : g_entry
      logic [BW-1:0] r_key;

      always_ff @(posedge clk) begin
        if (i_we && (i_widx == rnd_t'(gi))) begin
          r_key <= i_wdata;
        end
      end

      assign w_entry[gi] = r_key;
    end
  endgenerate

  always_comb begin
    o_rdata = '0;
    if (key_idx_valid(i_ridx, NR)) begin
      o_rdata = w_entry[i_ridx];
    end
  end

endmodule

// File: rtl/invcipher_ctrl.sv
// Sequencer for the 11-cycle AES-128 inverse-cipher datapath.
//   clk   : clock
//   reset : synchronous, active-high
//   bus   : invcipher_ctrl_if.slave (key load, ciphertext in, plaintext out,
//           datapath reset/done/roundKey/in/out)
// One block in flight: IDLE -> LOAD -> ROUND x(NR-1) -> FINAL -> HOLD -> IDLE.
// The round counter rnd indexes the key table in every state, so the key
// presented to the datapath is always key[rnd], descending from NR to 0.
module invcipher_ctrl
  import aes_pkg::*;
#(
  parameter int NR = AES_NR,
  parameter int BW = AES_BW
) (
  input  logic            clk,
  input  logic            reset,
  invcipher_ctrl_if.slave bus
);

  localparam rnd_t RND_LOAD  = rnd_t'(NR);
  localparam rnd_t RND_FIRST = rnd_t'(NR - 1);

  ctrl_state_t   r_state;
  ctrl_state_t   w_state_next;
  rnd_t          r_rnd;
  rnd_t          w_rnd_next;
  logic [BW-1:0] r_in_buf;
  logic [BW-1:0] r_out_data;
  logic          r_out_valid;
  logic          r_keys_valid;

  logic          w_key_wr;
  logic          w_accept;
  logic          w_out_hs;
  logic          w_in_ready;
  logic          w_core_reset;
  logic          w_core_done;
  logic [BW-1:0] w_round_key;

  // Key table may only change while nothing is in flight.
  assign w_key_wr = (r_state == IDLE) && bus.key_we && key_idx_valid(bus.key_idx, NR);
  assign w_accept = (r_state == IDLE) && r_keys_valid && bus.in_valid;
  assign w_out_hs = (r_state == HOLD) && bus.out_ready;

  inv_round_key_table #(
    .NR(NR),
    .BW(BW)
  ) u_key_table (
    .clk    (clk),
    .i_we   (w_key_wr),
    .i_widx (bus.key_idx),
    .i_wdata(bus.key_data),
    .i_ridx (r_rnd),
    .o_rdata(w_round_key)
  );

  always_comb begin
    w_state_next = r_state;
    w_rnd_next   = r_rnd;
    w_in_ready   = 1'b0;
    w_core_reset = 1'b0;
    w_core_done  = 1'b1;   // datapath rests whenever it is not mid-round
    unique case (r_state)
      IDLE: begin
        w_in_ready = r_keys_valid;
        if (w_accept) begin
          w_state_next = LOAD;
          w_rnd_next   = RND_LOAD;
        end
      end
      LOAD: begin
        w_core_reset = 1'b1;   // initial AddRoundKey with key[NR]
        w_state_next = ROUND;
        w_rnd_next   = RND_FIRST;
      end
      ROUND: begin
        w_core_done = 1'b0;
        if (r_rnd != '0) begin
          w_rnd_next = r_rnd - rnd_t'(1);
        end
        // Last full round uses key[1]; FINAL then uses key[0].
        if (r_rnd <= rnd_t'(1)) begin
          w_state_next = FINAL;
        end
      end
      FINAL: begin
        w_state_next = HOLD;
      end
      HOLD: begin
        if (w_out_hs) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_rnd        <= '0;
      r_in_buf     <= '0;
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_keys_valid <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_rnd   <= w_rnd_next;

      if (w_accept) begin
        r_in_buf <= bus.in_data;
      end

      // The datapath output is valid only while FINAL presents key[0].
      if (r_state == FINAL) begin
        r_out_data  <= bus.core_out;
        r_out_valid <= 1'b1;
      end else if (w_out_hs) begin
        r_out_valid <= 1'b0;
      end

      // Commit wins over a same-cycle write so a load can finish in one beat.
      if ((r_state == IDLE) && bus.key_commit) begin
        r_keys_valid <= 1'b1;
      end else if (w_key_wr) begin
        r_keys_valid <= 1'b0;
      end
    end
  end

  assign bus.keys_valid = r_keys_valid;
  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_data   = r_out_data;
  assign bus.core_reset = w_core_reset;
  assign bus.core_done  = w_core_done;
  assign bus.core_key   = w_round_key;
  assign bus.core_in    = r_in_buf;

endmodule

// File: tb/tb_invcipher_ctrl.sv
// Self-checking bench for invcipher_ctrl. A behavioural invcipher datapath is
// attached to the core_* port; expected plaintexts come from a straight-line
// AES-128 decryption over the bench's copy of the round-key table.
module tb_invcipher_ctrl;
  import aes_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  invcipher_ctrl_if #(.BW(AES_BW)) bus ();

  invcipher_ctrl #(
    .NR(AES_NR),
    .BW(AES_BW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] sbox     [256];
  logic [7:0] inv_sbox [256];
  block_t     cur_keys [11];
  block_t     core_st = '0;

  typedef struct {
    block_t ct;
    int     hold;
    block_t exp;
  } vec_t;

  vec_t vecs[5];

  // ---------------- AES arithmetic ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xt(x);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  function automatic block_t inv_shift_rows(input block_t b);
    block_t o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = b[127-8*(r+4*((c-r+4)%4)) -: 8];
    return o;
  endfunction

  function automatic block_t inv_sub_bytes(input block_t b);
    block_t o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = inv_sbox[b[127-8*i -: 8]];
    return o;
  endfunction

  function automatic block_t inv_mix_columns(input block_t b);
    block_t o = '0;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = b[127-32*c -: 8];
      a1 = b[119-32*c -: 8];
      a2 = b[111-32*c -: 8];
      a3 = b[103-32*c -: 8];
      o[127-32*c -: 32] = {
        gmul(a0,8'h0e) ^ gmul(a1,8'h0b) ^ gmul(a2,8'h0d) ^ gmul(a3,8'h09),
        gmul(a0,8'h09) ^ gmul(a1,8'h0e) ^ gmul(a2,8'h0b) ^ gmul(a3,8'h0d),
        gmul(a0,8'h0d) ^ gmul(a1,8'h09) ^ gmul(a2,8'h0e) ^ gmul(a3,8'h0b),
        gmul(a0,8'h0b) ^ gmul(a1,8'h0d) ^ gmul(a2,8'h09) ^ gmul(a3,8'h0e)};
    end
    return o;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  // Reference: textbook inverse cipher over the whole key table.
  function automatic block_t ref_decrypt(input block_t ct);
    block_t s;
    s = ct ^ cur_keys[10];
    for (int r = 9; r >= 1; r--) begin
      s = inv_shift_rows(s);
      s = inv_sub_bytes(s);
      s = s ^ cur_keys[r];
      s = inv_mix_columns(s);
    end
    s = inv_shift_rows(s);
    s = inv_sub_bytes(s);
    return s ^ cur_keys[0];
  endfunction

  function automatic block_t rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic build_sboxes();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      if (x != 0)
        for (int y = 1; y < 256; y++)
          if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl8(inv,1) ^ rotl8(inv,2) ^ rotl8(inv,3) ^ rotl8(inv,4) ^ 8'h63;
      sbox[x] = s;
    end
    for (int x = 0; x < 256; x++) inv_sbox[sbox[x]] = 8'(x);
  endtask

  task automatic expand_key(input block_t key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) cur_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // ---------------- behavioural invcipher datapath ----------------
  always @(posedge clk) begin
    if (bus.core_reset)
      core_st <= bus.core_in ^ bus.core_key;
    else if (!bus.core_done)
      core_st <= inv_mix_columns(inv_sub_bytes(inv_shift_rows(core_st)) ^ bus.core_key);
  end

  always_comb bus.core_out = inv_sub_bytes(inv_shift_rows(core_st)) ^ bus.core_key;

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input block_t act, input block_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int w = 0;
    while (bus.in_ready !== 1'b1 && w < 20) begin
      tick();
      w++;
    end
    chk1("in_ready_before_accept", bus.in_ready, 1'b1);
  endtask

  task automatic load_keys(input bit commit_with_last);
    for (int i = 0; i < 11; i++) begin
      bus.key_we     = 1'b1;
      bus.key_idx    = 4'(i);
      bus.key_data   = cur_keys[i];
      bus.key_commit = commit_with_last && (i == 10);
      tick();
      if (i == 0) chk1("write_clears_keys_valid", bus.keys_valid, 1'b0);
    end
    bus.key_we     = 1'b0;
    bus.key_commit = 1'b0;
    if (!commit_with_last) begin
      chk1("uncommitted_in_ready", bus.in_ready, 1'b0);
      bus.key_commit = 1'b1;
      tick();
      bus.key_commit = 1'b0;
    end
    chk1("commit_keys_valid", bus.keys_valid, 1'b1);
    chk1("commit_in_ready", bus.in_ready, 1'b1);
    $display("[TB] key table loaded, commit_with_last=%0d", commit_with_last);
  endtask

  // One block end to end; hold = cycles out_ready stays low after out_valid.
  // disturb attempts key writes while the block is in ROUND.
  task automatic run_block(input block_t ct, input int hold, input block_t exp, input bit disturb);
    int     n;
    int     ndone0 = 0;
    int     nload  = 0;
    block_t cap;
    wait_ready();
    bus.out_ready = (hold == 0);
    bus.in_valid  = 1'b1;
    bus.in_data   = ct;
    tick();
    bus.in_valid  = 1'b0;
    bus.in_data   = rand128();
    n = 1;
    while (bus.out_valid !== 1'b1 && n < 40) begin
      chk1("busy_in_ready", bus.in_ready, 1'b0);
      if (bus.core_done === 1'b0) ndone0++;
      if (bus.core_reset === 1'b1) begin
        nload++;
        chk("load_core_in", bus.core_in, ct);
        chk("load_core_key", bus.core_key, cur_keys[10]);
      end
      if (disturb && (n == 3 || n == 4)) begin
        bus.key_we   = 1'b1;
        bus.key_idx  = 4'd5;
        bus.key_data = rand128();
      end else begin
        bus.key_we = 1'b0;
      end
      tick();
      n++;
    end
    bus.key_we = 1'b0;
    chki("latency", n, 12);
    chki("done_low_cycles", ndone0, 9);
    chki("load_cycles", nload, 1);
    chk("out_data", bus.out_data, exp);
    chk1("hold_core_done", bus.core_done, 1'b1);
    cap = bus.out_data;
    for (int h = 0; h < hold; h++) begin
      tick();
      chk1("hold_out_valid", bus.out_valid, 1'b1);
      chk("hold_out_data", bus.out_data, cap);
      chk1("hold_in_ready", bus.in_ready, 1'b0);
    end
    bus.out_ready = 1'b1;
    tick();
    chk1("after_hs_out_valid", bus.out_valid, 1'b0);
    chk1("after_hs_idle", bus.in_ready, 1'b1);
    bus.out_ready = 1'b0;
    $display("[TB] block ct=%h pt=%h latency=%0d hold=%0d disturb=%0d", ct, cap, n, hold, disturb);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    block_t c1, c2, ct;
    int     rdy_at, n_rdy, nout;
    int     out_c [2];
    block_t out_d [2];

    reset          = 1'b1;
    bus.key_we     = 1'b0;
    bus.key_idx    = '0;
    bus.key_data   = '0;
    bus.key_commit = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.out_ready  = 1'b0;

    build_sboxes();

    // Reset values
    repeat (3) tick();
    chk1("rst_keys_valid", bus.keys_valid, 1'b0);
    chk1("rst_in_ready", bus.in_ready, 1'b0);
    chk1("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_data", bus.out_data, '0);
    chk1("rst_core_reset", bus.core_reset, 1'b0);
    chk1("rst_core_done", bus.core_done, 1'b1);
    chk("rst_core_in", bus.core_in, '0);
    reset = 1'b0;
    tick();

    // No commit yet: ciphertext must be ignored
    bus.in_valid = 1'b1;
    bus.in_data  = rand128();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk1("nokeys_in_ready", bus.in_ready, 1'b0);
      chk1("nokeys_core_reset", bus.core_reset, 1'b0);
    end
    bus.in_valid = 1'b0;
    chk("nokeys_not_latched", bus.core_in, '0);
    $display("[TB] in_valid without keys ignored");

    // FIPS-197 C.1 key schedule, write+commit on the last beat
    expand_key(128'h000102030405060708090a0b0c0d0e0f);
    load_keys(1'b1);

    // Out-of-range index is ignored entirely
    bus.key_we   = 1'b1;
    bus.key_idx  = 4'd12;
    bus.key_data = rand128();
    tick();
    bus.key_we   = 1'b0;
    chk1("idx12_keys_valid", bus.keys_valid, 1'b1);
    $display("[TB] key_idx=12 write issued");

    // Vector table
    vecs[0] = '{128'h69c4e0d86a7b0430d8cdb78070b4c55a, 0, 128'h00112233445566778899aabbccddeeff};
    for (int i = 1; i < 5; i++) begin
      ct = rand128();
      vecs[i] = '{ct, (i == 1) ? 0 : (i == 2) ? 3 : (i == 3) ? 20 : 1, ref_decrypt(ct)};
    end
    for (int i = 0; i < 5; i++) run_block(vecs[i].ct, vecs[i].hold, vecs[i].exp, 1'b0);

    // Back-to-back with out_ready held high
    c1 = rand128();
    c2 = rand128();
    rdy_at = 0;
    n_rdy  = 0;
    nout   = 0;
    out_c[0] = 0;
    out_c[1] = 0;
    out_d[0] = '0;
    out_d[1] = '0;
    wait_ready();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = c1;
    tick();
    bus.in_data   = c2;
    for (int c = 1; c <= 25; c++) begin
      if (bus.in_ready === 1'b1) begin
        n_rdy++;
        rdy_at = c;
      end
      if (bus.out_valid === 1'b1) begin
        if (nout < 2) begin
          out_c[nout] = c;
          out_d[nout] = bus.out_data;
        end
        nout++;
      end
      tick();
      if (rdy_at != 0) bus.in_valid = 1'b0;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chki("b2b_ready_cycles", n_rdy, 1);
    chki("b2b_ready_at", rdy_at, 13);
    chki("b2b_outputs", nout, 2);
    chki("b2b_first_out", out_c[0], 12);
    chki("b2b_spacing", out_c[1] - out_c[0], 13);
    chk("b2b_data1", out_d[0], ref_decrypt(c1));
    chk("b2b_data2", out_d[1], ref_decrypt(c2));
    chk1("b2b_idle_after", bus.in_ready, 1'b1);
    $display("[TB] back-to-back outputs at cycles %0d and %0d", out_c[0], out_c[1]);

    // Key writes during ROUND are ignored
    ct = rand128();
    run_block(ct, 2, ref_decrypt(ct), 1'b1);
    chk1("disturb_keys_valid", bus.keys_valid, 1'b1);
    ct = rand128();
    run_block(ct, 0, ref_decrypt(ct), 1'b0);

    // Reset while rnd=5
    wait_ready();
    ct = rand128();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = ct;
    tick();
    bus.in_valid  = 1'b0;
    repeat (5) tick();
    chk("rnd5_core_key", bus.core_key, cur_keys[5]);
    chk1("rnd5_core_done", bus.core_done, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk1("abort_out_valid", bus.out_valid, 1'b0);
    chk1("abort_core_done", bus.core_done, 1'b1);
    chk1("abort_core_reset", bus.core_reset, 1'b0);
    chk1("abort_keys_valid", bus.keys_valid, 1'b0);
    chk1("abort_in_ready", bus.in_ready, 1'b0);
    bus.key_commit = 1'b1;
    tick();
    bus.key_commit = 1'b0;
    chk1("recommit_in_ready", bus.in_ready, 1'b1);
    chk1("recommit_out_valid", bus.out_valid, 1'b0);
    $display("[TB] reset during ROUND, table recommitted");
    ct = rand128();
    run_block(ct, 1, ref_decrypt(ct), 1'b0);

    // Random round keys and random traffic
    for (int i = 0; i < 11; i++) cur_keys[i] = rand128();
    load_keys(1'b0);
    for (int i = 0; i < 8; i++) begin
      ct = rand128();
      run_block(ct, int'($urandom_range(0, 4)), ref_decrypt(ct), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

endmodule
